// File: rtl/bios_mem_hex_dumper_pkg.sv
// Shared BIOS/UART definitions: dumper FSM encoding, ASCII constants, word geometry.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bios_mem_hex_dumper_pkg;

    // Hex dumper FSM states.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_EMIT    = 3'd3,
        S_NEWLINE = 3'd4,
        S_DONE    = 3'd5
    } dump_state_t;

    // ASCII characters used to build readmemh-compatible text.
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_LC_A = 8'h61;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // BIOS memory word and UART character geometry.
    localparam int BIOS_WORD_WIDTH     = 32;
    localparam int HEX_DIGITS_PER_WORD = BIOS_WORD_WIDTH / 4;
    localparam int UART_DATA_BITS      = 8;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Converts one 4-bit nibble into its lowercase ASCII hex digit ('0'-'9', 'a'-'f').
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the input.
// Ports: nibble (in, 4b), ascii (out, 8b).
module hex_nibble_to_ascii
    import bios_mem_hex_dumper_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_ZERO + {4'h0, nibble};
        end else begin
            ascii = ASCII_LC_A + {4'h0, nibble - 4'd10};
        end
    end

endmodule

// File: rtl/bios_mem_hex_dumper.sv
// Dumps a range of BIOS memory words as readmemh text: 8 lowercase hex digits + LF per word.
// Latency: first byte valid 3 cycles after the start edge (READ, CAPTURE, EMIT).
// Backpressure: valid/ready byte stream; out_data/out_valid hold while out_ready is low.
// Ports: clk, rst (async active-low); start/start_addr/word_count request a dump;
//        mem_en/mem_addr/mem_dout form the 1-cycle-latency memory read port;
//        out_data/out_valid/out_ready carry ASCII bytes; busy and done report status.
module bios_mem_hex_dumper
    import bios_mem_hex_dumper_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    dump_state_t           state;
    dump_state_t           state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [DATA_WIDTH-1:0] shreg;
    logic [2:0]            nib_cnt;
    logic [7:0]            nib_ascii;

    // The most significant nibble of the shift register is always the next digit.
    hex_nibble_to_ascii u_hex (
        .nibble (shreg[DATA_WIDTH-1 -: 4]),
        .ascii  (nib_ascii)
    );

    // The address register doubles as the memory address; it only changes between reads.
    assign mem_addr = addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (word_count == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                mem_en    = 1'b1;
                state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_nxt = S_EMIT;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                out_data  = nib_ascii;
                if (out_ready && nib_cnt == 3'd7) begin
                    state_nxt = S_NEWLINE;
                end
            end
            S_NEWLINE: begin
                out_valid = 1'b1;
                out_data  = ASCII_LF;
                if (out_ready) begin
                    state_nxt = (remaining == (ADDR_WIDTH+1)'(1)) ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Request parameters are captured only in IDLE, so a start while busy has no effect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr      <= '0;
            remaining <= '0;
            shreg     <= '0;
            nib_cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        addr      <= start_addr;
                        remaining <= word_count;
                    end
                end
                S_CAPTURE: begin
                    shreg   <= mem_dout;
                    nib_cnt <= '0;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        shreg   <= shreg << 4;
                        nib_cnt <= nib_cnt + 3'd1;
                    end
                end
                S_NEWLINE: begin
                    if (out_ready) begin
                        remaining <= remaining - 1'b1;
                        addr      <= addr + 1'b1;   // wraps naturally at all-ones
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bios_mem_hex_dumper.sv
module tb_bios_mem_hex_dumper;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   word_count;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_dout;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    logic ready_fix  = 1'b1;
    logic rand_ready = 1'b0;
    logic rnd_bit    = 1'b0;

    assign out_ready = rand_ready ? rnd_bit : ready_fix;

    always #5 clk = ~clk;

    bios_mem_hex_dumper #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    // Behavioural BIOS ROM with one cycle of read latency.
    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (mem_en) mem_dout <= mem[mem_addr];
    end

    always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

    // Stream monitor: sole writer of all observation state.
    byte unsigned  rx_q[$];
    logic [AW-1:0] addr_q[$];
    int            done_cnt  = 0;
    int            vld_cnt   = 0;
    int            en_cnt    = 0;
    int            stall_err = 0;
    logic          stall_pend = 1'b0;
    logic [7:0]    stall_dat  = 8'h00;

    always @(posedge clk) begin
        if (!rst) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend && (!out_valid || out_data != stall_dat)) stall_err++;
            stall_pend = out_valid && !out_ready;
            stall_dat  = out_data;
            if (out_valid && out_ready) rx_q.push_back(out_data);
            if (out_valid) vld_cnt++;
            if (mem_en) begin
                en_cnt++;
                addr_q.push_back(mem_addr);
            end
            if (done) done_cnt++;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic string hexline(input logic [31:0] w);
        return $sformatf("%08x\n", w);
    endfunction

    task automatic chk_stream(input string tag, input int base, input string exp);
        chk({tag, "_len"}, 32'(rx_q.size() - base), 32'(exp.len()));
        for (int i = 0; i < exp.len(); i++) begin
            if (base + i < rx_q.size()) chk(tag, 32'(rx_q[base + i]), 32'(exp[i]));
        end
    endtask

    // Returns at the negedge after the sampling edge, i.e. in the first post-start cycle.
    task automatic start_dump(input logic [AW-1:0] a, input logic [AW:0] n);
        @(negedge clk);
        start      = 1'b1;
        start_addr = a;
        word_count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (done) break;
            @(negedge clk);
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    int base, dbase, vbase, ebase, abase;

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        word_count = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[0]     = 32'hDEADBEEF;
        mem[1]     = 32'h00000001;
        mem[4]     = 32'h0000012C;
        mem[4095]  = 32'hA5A5A5A5;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b1;
        @(negedge clk);

        // Single word, ready always high, with first-byte latency
        base = rx_q.size(); dbase = done_cnt;
        start_dump(12'd4, 13'd1);
        chk("t1_read_en", 32'(mem_en), 1);
        chk("t1_read_addr", 32'(mem_addr), 4);
        chk("t1_read_vld", 32'(out_valid), 0);
        chk("t1_busy", 32'(busy), 1);
        @(negedge clk);
        chk("t1_cap_en", 32'(mem_en), 0);
        chk("t1_cap_vld", 32'(out_valid), 0);
        @(negedge clk);
        chk("t1_emit_vld", 32'(out_valid), 1);
        chk("t1_emit_dat", 32'(out_data), 32'h30);
        wait_done("t1");
        chk_stream("t1_stream", base, "0000012c\n");
        chk("t1_done_cnt", 32'(done_cnt - dbase), 1);

        // Two words under random backpressure
        base = rx_q.size(); dbase = done_cnt;
        rand_ready = 1'b1;
        start_dump(12'd0, 13'd2);
        wait_done("t2");
        rand_ready = 1'b0;
        chk_stream("t2_stream", base, {hexline(32'hDEADBEEF), hexline(32'h1)});
        chk("t2_stall_stable", 32'(stall_err), 0);
        chk("t2_done_cnt", 32'(done_cnt - dbase), 1);

        // Zero-length dump
        vbase = vld_cnt; ebase = en_cnt;
        start_dump(12'd0, 13'd0);
        chk("t3_done", 32'(done), 1);
        chk("t3_mem_en", 32'(mem_en), 0);
        chk("t3_vld", 32'(out_valid), 0);
        @(negedge clk);
        chk("t3_done_1cyc", 32'(done), 0);
        chk("t3_idle", 32'(busy), 0);
        chk("t3_vld_cnt", 32'(vld_cnt - vbase), 0);
        chk("t3_en_cnt", 32'(en_cnt - ebase), 0);

        // Address wrap from all-ones to zero
        base = rx_q.size(); abase = addr_q.size();
        start_dump(12'hFFF, 13'd2);
        wait_done("t4");
        chk("t4_addr_n", 32'(addr_q.size() - abase), 2);
        if (addr_q.size() - abase == 2) begin
            chk("t4_addr0", 32'(addr_q[abase]), 32'hFFF);
            chk("t4_addr1", 32'(addr_q[abase + 1]), 32'h000);
        end
        chk_stream("t4_stream", base, {hexline(32'hA5A5A5A5), hexline(32'hDEADBEEF)});

        // Reset after the third byte, then a fresh dump
        base = rx_q.size(); dbase = done_cnt;
        start_dump(12'd0, 13'd2);
        for (int i = 0; i < 100; i++) begin
            if (rx_q.size() - base >= 3) break;
            @(negedge clk);
        end
        chk("t5_three_bytes", 32'(rx_q.size() - base), 3);
        rst = 1'b0;
        #1;
        chk("t5_rst_mem_en", 32'(mem_en), 0);
        chk("t5_rst_mem_addr", 32'(mem_addr), 0);
        chk("t5_rst_vld", 32'(out_valid), 0);
        chk("t5_rst_dat", 32'(out_data), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_done", 32'(done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_no_done", 32'(done_cnt - dbase), 0);
        chk("t5_idle", 32'(busy), 0);
        base = rx_q.size();
        start_dump(12'd4, 13'd1);
        wait_done("t5b");
        chk_stream("t5_stream", base, "0000012c\n");

        // Second start while busy is ignored
        base = rx_q.size(); dbase = done_cnt; abase = addr_q.size();
        start_dump(12'd0, 13'd2);
        repeat (4) @(negedge clk);
        start = 1'b1; start_addr = 12'd4; word_count = 13'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t6");
        chk_stream("t6_stream", base, {hexline(32'hDEADBEEF), hexline(32'h1)});
        chk("t6_done_cnt", 32'(done_cnt - dbase), 1);
        chk("t6_addr_n", 32'(addr_q.size() - abase), 2);
        if (addr_q.size() - abase == 2) begin
            chk("t6_addr0", 32'(addr_q[abase]), 0);
            chk("t6_addr1", 32'(addr_q[abase + 1]), 1);
        end
        repeat (3) @(negedge clk);
        chk("t6_still_idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
